escalonador_quantum_rr: RTL and testbench
=========================================

Name: escalonador_quantum_rr

Overview:
- Parametrised successor to the single-process quantum counter.
- Tracks up to NUM_PROC processes: per-process saved PC, active mask, round-robin next-process selection.
- Time-slice counter with runtime-selectable quantum, plus IO trap and process-end handling.
- Sits beside the PC update logic in the CPU. Outputs drive the redirect to the scheduler (ESC_ADDR) or IO handler (IO_ADDR) and supply the PC that the register mux stores on a context switch.

Parameters:
- NUM_PROC, 4, process slots incl. pid 0 (OS/scheduler, never time-sliced); must be >=2.
- PC_W, 32, PC / saved-PC width.
- QUANTUM, 16, default slice length in executed cycles; must be >=2.
- CNT_W, 8, quantum counter width; QUANTUM < 2^CNT_W.
- ESC_ADDR, 1, scheduler entry address.
- IO_ADDR, 10, IO handler entry address.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  PC_W  current CPU PC.
- proc_atual  in  PID_W=$clog2(NUM_PROC)  pid currently selected by the OS.
- parada  in  1  CPU halted; freezes the counter.
- instr_io  in  1  current instruction is IO (user process).
- fim_processo  in  1  current instruction ends the process.
- ativa_proc  in  1  one-cycle strobe: activate slot ativa_pid at ativa_pc.
- ativa_pid  in  PID_W  slot to activate.
- ativa_pc  in  PC_W  start PC of the activated slot.
- troca_contexto  out  2  00 none, 11 quantum expired, 10 process ended; one-cycle pulse.
- desvio_io  out  1  one-cycle pulse: CPU redirects to IO_ADDR.
- pc_destino  out  PC_W  ESC_ADDR or IO_ADDR while a pulse is active, else 0.
- pc_contexto  out  PC_W  saved PC of proc_proximo (combinational table read).
- proc_proximo  out  PID_W  registered round-robin choice; 0 if no active user process.
- proc_ativos  out  NUM_PROC  active mask; bit 0 always 0.
- quantum_restante  out  CNT_W  cycles left in the current slice.

Behaviour:
- Reset (reset=0, async) clears:
  - all outputs = 0, FSM = OCIOSO;
  - saved-PC table = 0, active mask = 0;
  - counter = 0, quantum register = QUANTUM.
- FSM states:
  - OCIOSO: pid 0 running, counter held at 0.
  - EXECUTA: user process running.
  - TROCA: one cycle; emits troca_contexto.
  - TRAP_IO: one cycle; emits desvio_io.
- OCIOSO -> EXECUTA when proc_atual != 0 and its active bit is set. On entry, counter loads quantum-1 and quantum_restante = quantum. proc_atual != 0 with an inactive bit is ignored and the FSM stays in OCIOSO.
- EXECUTA, priority fim_processo > instr_io > expiry:
  - Counter decrements each cycle with parada=0; parada=1 holds it and suppresses expiry.
  - fim_processo=1: clear active bit of proc_atual -> TROCA with code 10.
  - instr_io=1: table[proc_atual] <= pc+1 -> TRAP_IO.
  - Counter==0 with parada=0: table[proc_atual] <= pc -> TROCA with code 11.
  - proc_atual falling to 0: -> OCIOSO, no pulse.
- TROCA:
  - troca_contexto = code for exactly one cycle; pc_destino = ESC_ADDR.
  - proc_proximo <= first active pid strictly after proc_atual, cyclic over 1..NUM_PROC-1 (wraps past NUM_PROC-1 to 1). The current pid is eligible only if it is the sole active one. 0 if the mask is empty.
  - Next state OCIOSO.
- TRAP_IO: desvio_io=1 for one cycle, pc_destino = IO_ADDR, counter frozen; next state OCIOSO. The slice restarts at full quantum on re-entry.
- ativa_proc, any state:
  - table[ativa_pid] <= ativa_pc; set active bit.
  - ativa_pid=0 is ignored.
  - Same-cycle ativa_proc on the pid being ended: activation wins and the bit stays set.
- proc_proximo also recomputes in OCIOSO whenever the mask changes.
- Asserting reset mid-TROCA/TRAP_IO aborts the pulse immediately (async clear).

Optional Feature:
- QUANTUM_PROG_EN defined:
  - Adds ports quantum_wr (in, 1) and quantum_val (in, CNT_W).
  - quantum_wr=1 loads the quantum register; quantum_val<2 is clamped to 2.
  - Takes effect at the next EXECUTA entry; an in-progress slice is unaffected.
- Undefined: no extra ports; quantum fixed at QUANTUM.

Test Plan:
- Reset low mid-run -> all outputs 0, mask 0, FSM OCIOSO within the same cycle.
- Activate pids 1 (pc 100) and 2 (pc 200); proc_atual=1; pc=105, parada=0 for 16 cycles -> troca_contexto=11 on cycle 16, pc_destino=1, table[1]=pc at expiry, proc_proximo=2, pc_contexto=200.
- Within the same slice, parada=1 for 5 cycles -> expiry delayed exactly 5 cycles.
- instr_io=1 at pc=120 with pid 1 -> desvio_io one cycle, pc_destino=10, table[1]=121, troca_contexto=00.
- fim_processo and instr_io together with pid 2 (only 1,2 active) -> troca_contexto=10, mask=0b0010, proc_proximo=1, no desvio_io.
- QUANTUM_PROG_EN: write quantum_val=4 then enter EXECUTA -> expiry after 4 cycles; quantum_val=1 -> clamped, expiry after 2.

Source files
------------

// File: rtl/escalonador_quantum_rr.sv
// Round-robin time-slice scheduler: per-process saved PC, active mask and quantum counter.
// Define QUANTUM_PROG_EN to add a runtime-writable quantum (quantum_wr / quantum_val).
module escalonador_quantum_rr #(
  parameter int unsigned NUM_PROC = 4,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned QUANTUM  = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ESC_ADDR = 1,
  parameter int unsigned IO_ADDR  = 10,
  localparam int unsigned PID_W   = $clog2(NUM_PROC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_W-1:0]     pc,
  input  logic [PID_W-1:0]    proc_atual,
  input  logic                parada,
  input  logic                instr_io,
  input  logic                fim_processo,
  input  logic                ativa_proc,
  input  logic [PID_W-1:0]    ativa_pid,
  input  logic [PC_W-1:0]     ativa_pc,
`ifdef QUANTUM_PROG_EN
  input  logic                quantum_wr,
  input  logic [CNT_W-1:0]    quantum_val,
`endif
  output logic [1:0]          troca_contexto,
  output logic                desvio_io,
  output logic [PC_W-1:0]     pc_destino,
  output logic [PC_W-1:0]     pc_contexto,
  output logic [PID_W-1:0]    proc_proximo,
  output logic [NUM_PROC-1:0] proc_ativos,
  output logic [CNT_W-1:0]    quantum_restante
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, TROCA, TRAP_IO} estado_t;

  localparam logic [1:0] COD_NADA    = 2'b00;
  localparam logic [1:0] COD_EXPIROU = 2'b11;
  localparam logic [1:0] COD_FIM     = 2'b10;

  estado_t             estado_q, estado_d;
  logic [PC_W-1:0]     tabela_q [NUM_PROC];
  logic [PC_W-1:0]     tabela_d [NUM_PROC];
  logic [NUM_PROC-1:0] ativos_q, ativos_d;
  logic                mudou_q, mudou_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    quantum_q, quantum_d;
  logic [CNT_W-1:0]    restante_q, restante_d;
  logic [1:0]          troca_q, troca_d;
  logic                desvio_q, desvio_d;
  logic [PC_W-1:0]     destino_q, destino_d;
  logic [PID_W-1:0]    proximo_q, proximo_d;
  logic [PID_W-1:0]    rr_pid;

  // First active user pid after proc_atual, cycling over 1..NUM_PROC-1; the current pid is tried last.
  always_comb begin
    int unsigned base;
    int unsigned cand;
    rr_pid = '0;
    cand   = 0;
    base   = (proc_atual == '0) ? (NUM_PROC - 2) : (32'(proc_atual) - 32'd1);
    for (int unsigned k = NUM_PROC - 1; k >= 1; k--) begin
      cand = ((base + k) % (NUM_PROC - 1)) + 1;
      if (ativos_q[PID_W'(cand)]) rr_pid = PID_W'(cand);
    end
  end

  always_comb begin
    estado_d   = estado_q;
    tabela_d   = tabela_q;
    ativos_d   = ativos_q;
    cnt_d      = cnt_q;
    quantum_d  = quantum_q;
    restante_d = restante_q;
    troca_d    = COD_NADA;
    desvio_d   = 1'b0;
    destino_d  = '0;
    proximo_d  = proximo_q;

    case (estado_q)
      OCIOSO: begin
        cnt_d      = '0;
        restante_d = '0;
        if (mudou_q) proximo_d = rr_pid;
        if (proc_atual != '0 && ativos_q[proc_atual]) begin
          estado_d   = EXECUTA;
          cnt_d      = quantum_q - CNT_W'(1);
          restante_d = quantum_q;
        end
      end
      EXECUTA: begin
        if (proc_atual == '0) begin
          estado_d   = OCIOSO;
          cnt_d      = '0;
          restante_d = '0;
        end else if (fim_processo) begin
          ativos_d[proc_atual] = 1'b0;
          estado_d  = TROCA;
          troca_d   = COD_FIM;
          destino_d = PC_W'(ESC_ADDR);
        end else if (instr_io) begin
          tabela_d[proc_atual] = pc + PC_W'(1);
          estado_d  = TRAP_IO;
          desvio_d  = 1'b1;
          destino_d = PC_W'(IO_ADDR);
        end else if (!parada) begin
          if (cnt_q == '0) begin
            tabela_d[proc_atual] = pc;
            estado_d   = TROCA;
            troca_d    = COD_EXPIROU;
            destino_d  = PC_W'(ESC_ADDR);
            restante_d = '0;
          end else begin
            cnt_d      = cnt_q - CNT_W'(1);
            restante_d = cnt_q;
          end
        end
      end
      TROCA: begin
        proximo_d = rr_pid;
        estado_d  = OCIOSO;
      end
      TRAP_IO: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase

    // Activation is applied last so it overrides a same-cycle end of that pid.
    if (ativa_proc && ativa_pid != '0) begin
      tabela_d[ativa_pid] = ativa_pc;
      ativos_d[ativa_pid] = 1'b1;
    end
    ativos_d[0] = 1'b0;

`ifdef QUANTUM_PROG_EN
    if (quantum_wr) quantum_d = (quantum_val < CNT_W'(2)) ? CNT_W'(2) : quantum_val;
`endif

    mudou_d = (ativos_d != ativos_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      tabela_q   <= '{default: '0};
      ativos_q   <= '0;
      mudou_q    <= 1'b0;
      cnt_q      <= '0;
      quantum_q  <= CNT_W'(QUANTUM);
      restante_q <= '0;
      troca_q    <= COD_NADA;
      desvio_q   <= 1'b0;
      destino_q  <= '0;
      proximo_q  <= '0;
    end else begin
      estado_q   <= estado_d;
      tabela_q   <= tabela_d;
      ativos_q   <= ativos_d;
      mudou_q    <= mudou_d;
      cnt_q      <= cnt_d;
      quantum_q  <= quantum_d;
      restante_q <= restante_d;
      troca_q    <= troca_d;
      desvio_q   <= desvio_d;
      destino_q  <= destino_d;
      proximo_q  <= proximo_d;
    end
  end

  assign troca_contexto   = troca_q;
  assign desvio_io        = desvio_q;
  assign pc_destino       = destino_q;
  assign pc_contexto      = tabela_q[proximo_q];
  assign proc_proximo     = proximo_q;
  assign proc_ativos      = ativos_q;
  assign quantum_restante = restante_q;

endmodule

// File: tb/tb_escalonador_quantum_rr.sv
// Scoreboard bench for escalonador_quantum_rr: driver pushes expected pulses, monitor pops and compares.
module tb_escalonador_quantum_rr;

  localparam int NP  = 4;
  localparam int QD  = 16;
  localparam logic [31:0] ESC = 32'd1;
  localparam logic [31:0] IOA = 32'd10;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [1:0]  proc_atual;
  logic        parada, instr_io, fim_processo, ativa_proc;
  logic [1:0]  ativa_pid;
  logic [31:0] ativa_pc;
`ifdef QUANTUM_PROG_EN
  logic        quantum_wr;
  logic [7:0]  quantum_val;
`endif
  logic [1:0]  troca_contexto;
  logic        desvio_io;
  logic [31:0] pc_destino, pc_contexto;
  logic [1:0]  proc_proximo;
  logic [3:0]  proc_ativos;
  logic [7:0]  quantum_restante;

  escalonador_quantum_rr dut (
    .clock(clock), .reset(reset), .pc(pc), .proc_atual(proc_atual), .parada(parada),
    .instr_io(instr_io), .fim_processo(fim_processo), .ativa_proc(ativa_proc),
    .ativa_pid(ativa_pid), .ativa_pc(ativa_pc),
`ifdef QUANTUM_PROG_EN
    .quantum_wr(quantum_wr), .quantum_val(quantum_val),
`endif
    .troca_contexto(troca_contexto), .desvio_io(desvio_io), .pc_destino(pc_destino),
    .pc_contexto(pc_contexto), .proc_proximo(proc_proximo), .proc_ativos(proc_ativos),
    .quantum_restante(quantum_restante)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  code;
    logic        io;
    logic [31:0] dest;
    logic [3:0]  mask;
    int          prox;
    logic [31:0] ctx;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk, n_pass;

  // Reference model state: saved PCs, active set, expected next pid and quantum
  logic [31:0] m_pc [NP];
  logic [3:0]  m_mask;
  int          m_prox;
  int          m_q;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, want, $time);
  endfunction

  function automatic int rr_ref(int cur, logic [3:0] m);
    int c;
    for (int k = 1; k < NP; k++) begin
      c = cur + k;
      if (c >= NP) c = c - (NP - 1);
      if (m[c]) return c;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) m_pc[i] = '0;
    m_mask = '0;
    m_prox = 0;
    m_q    = QD;
  endfunction

  function automatic void push_exp(logic [1:0] code, logic io, logic [31:0] dest);
    exp_t e;
    e.code = code; e.io = io; e.dest = dest; e.mask = m_mask;
    e.prox = m_prox; e.ctx = m_pc[m_prox]; e.cyc = cyc + 1;
    sb.push_back(e);
  endfunction

  task automatic activate(input int pid, input logic [31:0] apc);
    logic [3:0] old;
    @(posedge clock); #1;
    ativa_proc = 1'b1; ativa_pid = 2'(pid); ativa_pc = apc;
    old = m_mask;
    if (pid != 0) begin
      m_mask[pid] = 1'b1;
      m_pc[pid]   = apc;
    end
    if (m_mask != old) m_prox = rr_ref(0, m_mask);
    @(posedge clock); #1;
    ativa_proc = 1'b0;
    @(posedge clock); #1;
    chk("act_mask", 64'(proc_ativos), 64'(m_mask));
    chk("act_proximo", 64'(proc_proximo), 64'(m_prox));
    chk("act_pc_contexto", 64'(pc_contexto), 64'(m_pc[m_prox]));
  endtask

`ifdef QUANTUM_PROG_EN
  task automatic set_q(input int v);
    @(posedge clock); #1;
    quantum_wr = 1'b1; quantum_val = 8'(v);
    @(posedge clock); #1;
    quantum_wr = 1'b0;
    m_q = (v < 2) ? 2 : v;
  endtask
`endif

  // kind: 0 expiry, 1 IO trap at executed count at_n, 2 process end, 3 end + IO together
  task automatic run_slice(input int p, input int kind, input int at_n, input int halt_pct,
                           input int burst, input logic [31:0] pc_fix, input int act_pid,
                           input bit do_rst);
    int n, it;
    bit done, h;
    logic [31:0] pcv, apc;
    n = 0; it = 0; done = 1'b0;
    @(posedge clock); #1;
    proc_atual = 2'(p);
    while (!done && it < 2000) begin
      @(posedge clock); #1;
      it++;
      if (it == 1) chk("restante_entry", 64'(quantum_restante), 64'(m_q));
      pcv = (pc_fix != 0) ? pc_fix : $urandom;
      pc  = pcv;
      if (kind != 0 && n == at_n) begin
        parada = 1'b0;
        fim_processo = (kind >= 2);
        instr_io     = (kind == 1 || kind == 3);
        if (kind >= 2) begin
          m_mask[p] = 1'b0;
          if (act_pid >= 0) begin
            apc = $urandom;
            ativa_proc = 1'b1; ativa_pid = 2'(act_pid); ativa_pc = apc;
            if (act_pid != 0) begin
              m_mask[act_pid] = 1'b1;
              m_pc[act_pid]   = apc;
            end
          end
          m_prox = rr_ref(p, m_mask);
          push_exp(2'b10, 1'b0, ESC);
        end else begin
          m_pc[p] = pcv + 32'd1;
          push_exp(2'b00, 1'b1, IOA);
        end
        done = 1'b1;
      end else begin
        h = (it >= 3 && it < 3 + burst) || ($urandom_range(0, 99) < halt_pct);
        parada = h;
        if (!h) begin
          n++;
          if (kind == 0 && n == m_q) begin
            m_pc[p] = pcv;
            m_prox  = rr_ref(p, m_mask);
            if (!do_rst) push_exp(2'b11, 1'b0, ESC);
            done = 1'b1;
          end
        end
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL slice_timeout: pid=%0d kind=%0d executed=%0d required=%0d", p, kind, n, m_q);
    end
    @(posedge clock); #1;
    parada = 1'b0; instr_io = 1'b0; fim_processo = 1'b0; ativa_proc = 1'b0;
    if (do_rst) begin
      chk("pulse_before_reset", 64'(troca_contexto), 64'(2'b11));
      reset = 1'b0;
      #1;
      chk("rst_troca", 64'(troca_contexto), 64'd0);
      chk("rst_destino", 64'(pc_destino), 64'd0);
      chk("rst_mask", 64'(proc_ativos), 64'd0);
      chk("rst_proximo", 64'(proc_proximo), 64'd0);
      chk("rst_contexto", 64'(pc_contexto), 64'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
    end
    @(posedge clock); #1;
    proc_atual = 2'd0;
    repeat (2) @(posedge clock);
  endtask

  // Monitor: every pulse must match the oldest expected entry
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && (troca_contexto != 2'b00 || desvio_io)) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pulse: troca=%0b desvio=%0b cyc=%0d", troca_contexto, desvio_io, cyc);
        end else begin
          e = sb.pop_front();
          chk("troca_code", 64'(troca_contexto), 64'(e.code));
          chk("desvio_io", 64'(desvio_io), 64'(e.io));
          chk("pc_destino", 64'(pc_destino), 64'(e.dest));
          chk("mask_at_pulse", 64'(proc_ativos), 64'(e.mask));
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          @(negedge clock);
          chk("troca_code_cleared", 64'(troca_contexto), 64'd0);
          chk("proc_proximo", 64'(proc_proximo), 64'(e.prox));
          chk("pc_contexto", 64'(pc_contexto), 64'(e.ctx));
        end
      end
    end
  end

  initial begin : driver
    int p, kind, act;
    n_chk = 0; n_pass = 0;
    reset = 1'b0; pc = '0; proc_atual = '0; parada = 1'b0; instr_io = 1'b0;
    fim_processo = 1'b0; ativa_proc = 1'b0; ativa_pid = '0; ativa_pc = '0;
`ifdef QUANTUM_PROG_EN
    quantum_wr = 1'b0; quantum_val = '0;
`endif
    model_reset();
    #2;
    chk("reset_troca", 64'(troca_contexto), 64'd0);
    chk("reset_desvio", 64'(desvio_io), 64'd0);
    chk("reset_destino", 64'(pc_destino), 64'd0);
    chk("reset_proximo", 64'(proc_proximo), 64'd0);
    chk("reset_mask", 64'(proc_ativos), 64'd0);
    chk("reset_restante", 64'(quantum_restante), 64'd0);
    chk("reset_contexto", 64'(pc_contexto), 64'd0);
    #10;
    reset = 1'b1;

    activate(1, 32'd100);
    activate(2, 32'd200);
    run_slice(1, 0, 0, 0, 0, 32'd105, -1, 1'b0);
    run_slice(1, 0, 0, 0, 5, 32'd0, -1, 1'b0);
    run_slice(1, 1, 3, 0, 0, 32'd120, -1, 1'b0);
    run_slice(2, 3, 2, 0, 0, 32'd0, -1, 1'b0);
    activate(2, 32'd300);
    activate(3, 32'd400);
    activate(0, 32'd999);
    run_slice(3, 2, 1, 0, 0, 32'd0, 3, 1'b0);

    for (int t = 0; t < 30; t++) begin
      if (m_mask[3:1] == 3'b000 || $urandom_range(0, 2) == 0)
        activate(int'($urandom_range(0, 3)), $urandom);
      if (m_mask[3:1] == 3'b000)
        activate(int'($urandom_range(1, 3)), $urandom);
      do p = int'($urandom_range(1, 3)); while (!m_mask[p]);
      kind = int'($urandom_range(0, 3));
      act  = (kind >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      run_slice(p, kind, int'($urandom_range(0, m_q - 1)), int'($urandom_range(0, 25)),
                0, 32'd0, act, 1'b0);
    end

`ifdef QUANTUM_PROG_EN
    activate(1, 32'd500);
    set_q(4);
    run_slice(1, 0, 0, 0, 0, 32'd0, -1, 1'b0);
    set_q(1);
    run_slice(1, 0, 0, 0, 0, 32'd0, -1, 1'b0);
    set_q(7);
    run_slice(1, 0, 0, 20, 0, 32'd0, -1, 1'b0);
`endif

    activate(1, 32'd77);
    run_slice(1, 0, 0, 0, 0, 32'd0, -1, 1'b1);
    activate(2, 32'd88);
    run_slice(2, 0, 0, 0, 0, 32'd0, -1, 1'b0);

    repeat (4) @(posedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
